// File: rtl/cr_cddip_sa_cntr_bank_pkg.sv
// Shared types and defaults for the SA statistics counter bank.
package cr_cddip_sa_cbPKG;

    localparam int SA_N_CNTRS  = 64;
    localparam int SA_CNT_BITS = 50;
    localparam int SA_N_EVENTS = 128;

    typedef enum logic {
        SA_RD_LIVE,
        SA_RD_SNAP
    } rd_src_e;

    typedef enum logic [1:0] {
        IDLE,
        CAP,
        RESP
    } rd_fsm_e;

    typedef enum logic {
        SA_WRAP,
        SA_SAT
    } cnt_mode_e;

endpackage

// File: rtl/cr_cddip_sa_cntr_bank_if.sv
// Indexed read port of the SA counter bank (req/ack handshake).
interface cr_cddip_sa_cntr_bank_if #(
    parameter int ADDR_BITS = 6,
    parameter int CNT_BITS  = 50
);
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_src;
    logic                 rd_ack;
    logic [CNT_BITS-1:0]  rd_data;
    logic                 rd_ovf;
    logic                 rd_err;

    modport master (
        output rd_req, rd_addr, rd_src,
        input  rd_ack, rd_data, rd_ovf, rd_err
    );

    modport slave (
        input  rd_req, rd_addr, rd_src,
        output rd_ack, rd_data, rd_ovf, rd_err
    );
endinterface

// File: rtl/cr_cddip_sa_cntr_bank_cntr.sv
// One statistics counter: live value, snapshot and sticky overflow.
module cr_cddip_sa_cntr #(
    parameter int CNT_BITS = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                sat,
    input  logic                snap,
    input  logic                clr_on_snap,
    input  logic                clr,
    input  logic                ovf_clr,
    output logic [CNT_BITS-1:0] live,
    output logic [CNT_BITS-1:0] snap_val,
    output logic                ovf
);
    logic [CNT_BITS:0]   sum;
    logic [CNT_BITS-1:0] live_nxt;
    logic                clear_now;
    logic                ovf_set;

    assign sum       = {1'b0, live} + {{CNT_BITS{1'b0}}, 1'b1};
    assign clear_now = clr | (snap & clr_on_snap);
    // clearing restarts at inc, so the same-cycle event is kept and cannot overflow
    assign ovf_set   = inc & sum[CNT_BITS] & ~clear_now;

    always_comb begin
        live_nxt = live;
        if (clear_now) begin
            live_nxt = {{(CNT_BITS-1){1'b0}}, inc};
        end else if (inc && !(sum[CNT_BITS] && sat)) begin
            live_nxt = sum[CNT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live     <= '0;
            snap_val <= '0;
            ovf      <= 1'b0;
        end else begin
            live <= live_nxt;
            if (snap) snap_val <= live;
            ovf <= ovf_set | (ovf & ~ovf_clr);
        end
    end
endmodule

// File: rtl/cr_cddip_sa_cntr_bank.sv
// SA statistics counter bank: N live counters, snapshot and indexed read port.
module cr_cddip_sa_cntr_bank
    import cr_cddip_sa_cbPKG::*;
#(
    parameter int N_CNTRS   = SA_N_CNTRS,
    parameter int CNT_BITS  = SA_CNT_BITS,
    parameter int N_EVENTS  = SA_N_EVENTS,
    parameter int SEL_BITS  = $clog2(N_EVENTS),
    parameter int ADDR_BITS = $clog2(N_CNTRS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_EVENTS-1:0]         evt_in,
    input  logic [N_CNTRS*SEL_BITS-1:0] cfg_sel,
    input  logic [N_CNTRS-1:0]          cfg_en,
    input  logic [N_CNTRS-1:0]          cfg_sat,
    input  logic                        snap_req,
    input  logic                        clear_on_snap,
    input  logic                        clear_live,
    input  logic                        ovf_clr,
    cr_cddip_sa_cntr_bank_if.slave      rd,
    output logic [N_CNTRS-1:0]          ovf
);
    logic [N_CNTRS-1:0]  inc;
    logic [CNT_BITS-1:0] live_q [N_CNTRS];
    logic [CNT_BITS-1:0] snap_q [N_CNTRS];

    for (genvar i = 0; i < N_CNTRS; i++) begin : g_cntr
        logic [SEL_BITS-1:0] sel;
        assign sel    = cfg_sel[i*SEL_BITS +: SEL_BITS];
        assign inc[i] = cfg_en[i] & (int'(sel) < N_EVENTS) & evt_in[sel];

        cr_cddip_sa_cntr #(
            .CNT_BITS(CNT_BITS)
        ) u_cntr (
            .clk         (clk),
            .rst         (rst),
            .inc         (inc[i]),
            .sat         (cfg_sat[i] == SA_SAT),
            .snap        (snap_req),
            .clr_on_snap (clear_on_snap),
            .clr         (clear_live),
            .ovf_clr     (ovf_clr),
            .live        (live_q[i]),
            .snap_val    (snap_q[i]),
            .ovf         (ovf[i])
        );
    end

    rd_fsm_e              state;
    rd_fsm_e              state_nxt;
    logic                 accept;
    logic                 load;
    logic [ADDR_BITS-1:0] addr_q;
    rd_src_e              src_q;
    logic [CNT_BITS-1:0]  sel_data;
    logic                 sel_ovf;
    logic                 sel_hit;
    logic [CNT_BITS-1:0]  data_q;
    logic                 ovf_q;
    logic                 err_q;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd.rd_req) begin
                    accept    = 1'b1;
                    state_nxt = CAP;
                end
            end
            CAP: begin
                load      = 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_data = '0;
        sel_ovf  = 1'b0;
        sel_hit  = 1'b0;
        for (int i = 0; i < N_CNTRS; i++) begin
            if (addr_q == ADDR_BITS'(i)) begin
                sel_hit  = 1'b1;
                sel_data = (src_q == SA_RD_SNAP) ? snap_q[i] : live_q[i];
                sel_ovf  = ovf[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            src_q  <= SA_RD_LIVE;
            data_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= rd.rd_addr;
                src_q  <= rd_src_e'(rd.rd_src);
            end
            if (load) begin
                data_q <= sel_data;
                ovf_q  <= sel_ovf;
                err_q  <= ~sel_hit;
            end
        end
    end

    assign rd.rd_ack  = (state == RESP);
    assign rd.rd_data = data_q;
    assign rd.rd_ovf  = ovf_q;
    assign rd.rd_err  = err_q;
endmodule

// File: tb/tb_cr_cddip_sa_cntr_bank.sv
// Bench for cr_cddip_sa_cntr_bank: reference model plus directed vectors.
module tb_cr_cddip_sa_cntr_bank;
    import cr_cddip_sa_cbPKG::*;

    localparam int N    = 48;
    localparam int CB   = 8;
    localparam int NE   = 16;
    localparam int SB   = 4;
    localparam int AB   = 6;
    localparam int MAXV = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NE-1:0] evt_in = '0;
    logic [N*SB-1:0] cfg_sel = '0;
    logic [N-1:0]  cfg_en = '0;
    logic [N-1:0]  cfg_sat = '0;
    logic          snap_req = 1'b0;
    logic          clear_on_snap = 1'b0;
    logic          clear_live = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [N-1:0]  ovf;

    cr_cddip_sa_cntr_bank_if #(.ADDR_BITS(AB), .CNT_BITS(CB)) rd ();

    cr_cddip_sa_cntr_bank #(
        .N_CNTRS (N),
        .CNT_BITS(CB),
        .N_EVENTS(NE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .evt_in       (evt_in),
        .cfg_sel      (cfg_sel),
        .cfg_en       (cfg_en),
        .cfg_sat      (cfg_sat),
        .snap_req     (snap_req),
        .clear_on_snap(clear_on_snap),
        .clear_live   (clear_live),
        .ovf_clr      (ovf_clr),
        .rd           (rd),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: counters as plain integers, read port as a countdown
    int m_live [N];
    int m_snap [N];
    bit m_ovf  [N];
    int m_cnt = 0;
    int m_addr = 0;
    bit m_src = 0;
    int e_data = 0;
    bit e_ovf = 0;
    bit e_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_live[i] = 0;
                m_snap[i] = 0;
                m_ovf[i]  = 0;
            end
            m_cnt = 0;
        end else begin
            if (m_cnt == 2) begin
                if (m_addr < N) begin
                    e_data = m_src ? m_snap[m_addr] : m_live[m_addr];
                    e_ovf  = m_ovf[m_addr];
                    e_err  = 0;
                end else begin
                    e_data = 0;
                    e_ovf  = 0;
                    e_err  = 1;
                end
            end
            if (m_cnt > 0) m_cnt--;
            else if (rd.rd_req) begin
                m_cnt  = 2;
                m_addr = int'(rd.rd_addr);
                m_src  = rd.rd_src;
            end
            for (int i = 0; i < N; i++) begin
                int s;
                bit inc;
                bit clr;
                bit set;
                s   = int'(cfg_sel[i*SB +: SB]);
                inc = cfg_en[i] && (s < NE) && evt_in[s];
                clr = clear_live || (snap_req && clear_on_snap);
                set = 0;
                if (snap_req) m_snap[i] = m_live[i];
                if (clr) m_live[i] = inc ? 1 : 0;
                else if (inc) begin
                    if (m_live[i] == MAXV) begin
                        set = 1;
                        if (!cfg_sat[i]) m_live[i] = 0;
                    end else begin
                        m_live[i] = m_live[i] + 1;
                    end
                end
                if (set) m_ovf[i] = 1;
                else if (ovf_clr) m_ovf[i] = 0;
            end
        end
    end

    logic [N-1:0] m_ovf_vec;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N; i++) m_ovf_vec[i] = m_ovf[i];
            chk("ovf_vec", 64'(ovf), 64'(m_ovf_vec));
            chk("rd_ack", 64'(rd.rd_ack), 64'(m_cnt == 1));
            if (m_cnt == 1) begin
                chk("rd_data", 64'(rd.rd_data), 64'(e_data));
                chk("rd_ovf", 64'(rd.rd_ovf), 64'(e_ovf));
                chk("rd_err", 64'(rd.rd_err), 64'(e_err));
            end
        end
    end

    task automatic do_read(input int addr, input bit src,
                           output logic [CB-1:0] d, output logic o,
                           output logic e, output int lat);
        d = '0;
        o = 1'b0;
        e = 1'b0;
        lat = -1;
        rd.rd_addr = AB'(addr);
        rd.rd_src  = src;
        rd.rd_req  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rd.rd_ack) begin
                lat = k;
                d = rd.rd_data;
                o = rd.rd_ovf;
                e = rd.rd_err;
                break;
            end
        end
        rd.rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic events(input int bitn, input int n);
        evt_in = '0;
        evt_in[bitn] = 1'b1;
        repeat (n) @(negedge clk);
        evt_in = '0;
    endtask

    logic [CB-1:0] d;
    logic o;
    logic e;
    int lat;
    int acks [$];
    int ack_seen;

    initial begin
        rd.rd_req  = 1'b0;
        rd.rd_addr = '0;
        rd.rd_src  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1;
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_ack", 64'(rd.rd_ack), 64'd0);
        chk("rst_data", 64'(rd.rd_data), 64'd0);
        chk("rst_err", 64'(rd.rd_err), 64'd0);

        // count ten events on counter 3, snapshot, read both copies
        cfg_sel[3*SB +: SB] = 4'd5;
        cfg_en[3] = 1'b1;
        events(5, 10);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        do_read(3, 1'b1, d, o, e, lat);
        chk("snap_data", 64'(d), 64'd10);
        chk("snap_lat", 64'(lat), 64'd2);
        do_read(3, 1'b0, d, o, e, lat);
        chk("live_data", 64'(d), 64'd10);

        // wrap on counter 0, saturate on counter 1
        cfg_en[1:0]  = 2'b11;
        cfg_sat[1]   = 1'b1;
        events(0, 257);
        do_read(0, 1'b0, d, o, e, lat);
        chk("wrap_data", 64'(d), 64'd1);
        chk("wrap_ovf", 64'(o), 64'd1);
        do_read(1, 1'b0, d, o, e, lat);
        chk("sat_data", 64'(d), 64'd255);
        chk("sat_ovf", 64'(o), 64'd1);
        chk("ovf_lo2", 64'(ovf[1:0]), 64'd3);

        // clear-on-snap with an event in the snap cycle
        cfg_sel[2*SB +: SB] = 4'd1;
        cfg_en[2] = 1'b1;
        events(1, 7);
        evt_in[1] = 1'b1;
        snap_req = 1'b1;
        clear_on_snap = 1'b1;
        @(negedge clk);
        evt_in = '0;
        snap_req = 1'b0;
        clear_on_snap = 1'b0;
        do_read(2, 1'b1, d, o, e, lat);
        chk("cos_snap", 64'(d), 64'd7);
        do_read(2, 1'b0, d, o, e, lat);
        chk("cos_live", 64'(d), 64'd1);

        // overflow set beats a same-cycle ovf_clr
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovfclr_all", 64'(ovf), 64'd0);
        cfg_sel[4*SB +: SB] = 4'd2;
        cfg_en[4] = 1'b1;
        events(2, 255);
        evt_in[2] = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        evt_in = '0;
        ovf_clr = 1'b0;
        chk("set_wins", 64'(ovf[4]), 64'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_alone", 64'(ovf), 64'd0);
        do_read(4, 1'b0, d, o, e, lat);
        chk("wrap4_data", 64'(d), 64'd0);

        // clear_live with a same-cycle event
        events(5, 3);
        evt_in[5] = 1'b1;
        clear_live = 1'b1;
        @(negedge clk);
        evt_in = '0;
        clear_live = 1'b0;
        do_read(3, 1'b0, d, o, e, lat);
        chk("clr_live", 64'(d), 64'd1);

        // out-of-range address
        do_read(50, 1'b0, d, o, e, lat);
        chk("oor_err", 64'(e), 64'd1);
        chk("oor_data", 64'(d), 64'd0);
        chk("oor_lat", 64'(lat), 64'd2);

        // held request: one ack every three cycles
        rd.rd_addr = AB'(3);
        rd.rd_src  = 1'b0;
        rd.rd_req  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rd.rd_ack) acks.push_back(k);
        end
        rd.rd_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_count", 64'(acks.size()), 64'd4);
        for (int j = 1; j < acks.size(); j++)
            chk("b2b_gap", 64'(acks[j] - acks[j-1]), 64'd3);

        // reset while the read FSM sits in CAP
        events(2, 256);
        chk("pre_rst_ovf", 64'(ovf[4]), 64'd1);
        rd.rd_addr = AB'(3);
        rd.rd_src  = 1'b0;
        rd.rd_req  = 1'b1;
        @(negedge clk);
        rd.rd_req = 1'b0;
        #2 rst = 1'b1;
        ack_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rd.rd_ack) ack_seen++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd.rd_ack) ack_seen++;
        end
        chk("rst_cap_ack", 64'(ack_seen), 64'd0);
        chk("rst_cap_ovf", 64'(ovf), 64'd0);
        do_read(3, 1'b0, d, o, e, lat);
        chk("rst_live", 64'(d), 64'd0);
        chk("rst_idle_lat", 64'(lat), 64'd2);
        do_read(4, 1'b1, d, o, e, lat);
        chk("rst_snap", 64'(d), 64'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
